// File: rtl/exp_align_stage_l.sv
// Exponent alignment stage for an FP adder.
// Shifts the smaller significand right by the exponent gap, 8 bits per cycle.
module exp_align_stage_l #(
  parameter int W  = 32,
  parameter int EW = 8,
  parameter int SW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [W-2:0]  DMP_i,
  input  logic [W-2:0]  DmP_i,
  input  logic          real_op_i,
  input  logic          sign_i,
  input  logic          zero_flag_i,
  output logic          busy_o,
  output logic          ready_o,
  output logic [EW-1:0] exp_o,
  output logic [SW+3:0] sig_M_o,
  output logic [SW+3:0] sig_m_o,
  output logic          real_op_o,
  output logic          sign_o,
  output logic          zero_flag_o
);

  localparam int MW = SW + 4;
  localparam int RW = $clog2(MW + 1);
  localparam logic [EW-1:0] SAT  = EW'(MW);
  localparam logic [RW-1:0] STEP = RW'(8);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SHIFT,
    DONE
  } state_t;

  state_t        state;
  logic [EW-1:0] exp_big;
  logic [EW-1:0] exp_sml;
  logic [MW-1:0] sig_big;
  logic [MW-1:0] sig_sml;
  logic          sticky;
  logic [RW-1:0] rem;
  logic          real_op_q;
  logic          sign_q;
  logic          zero_q;

  logic [EW-1:0] eff_big;
  logic [EW-1:0] eff_sml;
  logic [EW-1:0] d_raw;
  logic [RW-1:0] d_sat;
  logic [RW-1:0] k;
  logic [MW-1:0] mask;
  logic [MW-1:0] shifted;
  logic [MW-1:0] fin;
  logic          lost;
  logic          nsticky;
  logic          load;

  always_comb begin
    eff_big = (exp_big == '0) ? EW'(1) : exp_big;
    eff_sml = (exp_sml == '0) ? EW'(1) : exp_sml;
    d_raw   = eff_big - eff_sml;
    d_sat   = (d_raw > SAT) ? RW'(MW) : RW'(d_raw);
    k       = (rem > STEP) ? STEP : rem;
    mask    = (MW'(1) << k) - MW'(1);
    shifted = sig_sml >> k;
    lost    = |(sig_sml & mask);
    nsticky = sticky | lost;
    fin     = sig_sml;
    load    = 1'b0;
    // load marks the edge that enters DONE
    unique case (state)
      CALC: load = (d_sat == '0) || zero_q;
      SHIFT: begin
        fin  = {shifted[MW-1:1], shifted[0] | nsticky};
        load = (rem == k);
      end
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      exp_big     <= '0;
      exp_sml     <= '0;
      sig_big     <= '0;
      sig_sml     <= '0;
      sticky      <= 1'b0;
      rem         <= '0;
      real_op_q   <= 1'b0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      busy_o      <= 1'b0;
      ready_o     <= 1'b0;
      exp_o       <= '0;
      sig_M_o     <= '0;
      sig_m_o     <= '0;
      real_op_o   <= 1'b0;
      sign_o      <= 1'b0;
      zero_flag_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      if (load) begin
        exp_o       <= exp_big;
        sig_M_o     <= sig_big;
        sig_m_o     <= fin;
        real_op_o   <= real_op_q;
        sign_o      <= sign_q;
        zero_flag_o <= zero_q;
      end
      unique case (state)
        IDLE: begin
          if (start_i) begin
            exp_big   <= DMP_i[W-2:SW];
            exp_sml   <= DmP_i[W-2:SW];
            sig_big   <= {|DMP_i[W-2:SW], DMP_i[SW-1:0], 3'b000};
            sig_sml   <= {|DmP_i[W-2:SW], DmP_i[SW-1:0], 3'b000};
            real_op_q <= real_op_i;
            sign_q    <= sign_i;
            zero_q    <= zero_flag_i;
            busy_o    <= 1'b1;
            state     <= CALC;
          end
        end
        CALC: begin
          rem    <= d_sat;
          sticky <= 1'b0;
          state  <= load ? DONE : SHIFT;
        end
        SHIFT: begin
          sig_sml <= shifted;
          sticky  <= nsticky;
          rem     <= rem - k;
          if (load) state <= DONE;
        end
        DONE: begin
          ready_o <= 1'b1;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
